// File: rtl/binary_output_1.sv
// Binary (XNOR/popcount) neuron layer: one 64-bit activation vector in, 16 sign bits out,
// weights streamed from an external 1-cycle-latency memory in four 4-neuron phases.
module binary_output_1 #(
  parameter int VECTOR_COUNT = 30,
  parameter int IN_W         = 64,
  parameter int OUT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  input  logic [1:0]           block_sel,
  output logic                 w_en,
  output logic [3:0]           w_addr,
  input  logic [4*IN_W-1:0]    w_data,
  output logic [OUT_W-1:0]     data_out,
  output logic                 data_out_valid,
  output logic                 done
);

  localparam int         PC_W     = $clog2(IN_W + 1);
  localparam logic [4:0] LAST_CNT = 5'(VECTOR_COUNT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [4:0]        count_q;
  logic [IN_W-1:0]   data_p0;
  logic [1:0]        sel_p0;
  logic [OUT_W-1:0]  acc_p1;
  logic [3:0]        phase_bits;
  logic              accept, capture, finish;

  function automatic logic [PC_W-1:0] popcount(input logic [IN_W-1:0] v);
    logic [PC_W-1:0] s;
    s = '0;
    for (int i = 0; i < IN_W; i++) s = s + PC_W'(v[i]);
    return s;
  endfunction

  // Sign of 2*pc - IN_W; a tie binarizes to 0.
  function automatic logic binarize(input logic [PC_W-1:0] pc);
    return pc > PC_W'(IN_W / 2);
  endfunction

  always_comb begin
    for (int n = 0; n < 4; n++)
      phase_bits[n] = binarize(popcount(~(w_data[n*IN_W +: IN_W] ^ data_p0)));
  end

  // Step 0..3 issue reads for phases 0..3; steps 1..4 see the returning word of phase step-1.
  assign accept  = (state_q == IDLE) && data_in_valid;
  assign capture = (state_q == RUN) && (step_q != 3'd0) && (step_q != 3'd4);
  assign finish  = (state_q == RUN) && (step_q == 3'd4);

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    data_in_ready = 1'b0;
    w_en          = 1'b0;
    w_addr        = 4'd0;
    case (state_q)
      IDLE: begin
        data_in_ready = 1'b1;
        if (data_in_valid) begin
          state_d = RUN;
          step_d  = 3'd0;
        end
      end
      RUN: begin
        if (step_q != 3'd4) begin
          w_en   = 1'b1;
          w_addr = {sel_p0, step_q[1:0]};
          step_d = step_q + 3'd1;
        end else begin
          step_d  = 3'd0;
          state_d = (count_q == LAST_CNT) ? DONE : IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Stage p0: operand latch at acceptance; stage p1: per-phase result shift register.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p0 <= data_in;
      sel_p0  <= block_sel;
    end
    if (capture) acc_p1 <= {phase_bits, acc_p1[OUT_W-1:4]};
  end

  // Output stage: publish the full vector together with the last phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q        <= 5'd0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      done           <= 1'b0;
    end else begin
      data_out_valid <= finish;
      if (finish) begin
        data_out <= {phase_bits, acc_p1[OUT_W-1:4]};
        count_q  <= count_q + 5'd1;
        if (count_q == LAST_CNT) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_binary_output_1.sv
// Scoreboard bench for binary_output_1: directed vectors push expected words, a monitor
// pops and compares on every data_out_valid pulse.
module tb_binary_output_1;
  localparam int IN_W = 64;
  localparam int OUT_W = 16;
  localparam int VC = 30;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IN_W-1:0]   data_in = '0;
  logic              data_in_valid = 1'b0;
  logic              data_in_ready;
  logic [1:0]        block_sel = 2'd0;
  logic              w_en;
  logic [3:0]        w_addr;
  logic [4*IN_W-1:0] w_data;
  logic [OUT_W-1:0]  data_out;
  logic              data_out_valid;
  logic              done;

  binary_output_1 #(.VECTOR_COUNT(VC), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .block_sel(block_sel), .w_en(w_en), .w_addr(w_addr),
    .w_data(w_data), .data_out(data_out), .data_out_valid(data_out_valid), .done(done)
  );

  always #5 clk = ~clk;

  logic [4*IN_W-1:0] mem [16];
  always @(posedge clk) if (w_en) w_data <= mem[w_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] d; int c; } exp_t;
  exp_t       sb[$];
  logic [3:0] alog[$];
  int errors = 0, checks = 0, pulses = 0, done_wen = 0, accepts = 0;
  logic [15:0] last_out = '0;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: weight-read log, scoreboard pop, latency, done and hold checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (w_en) begin
        alog.push_back(w_addr);
        if (done) done_wen++;
      end
      if (data_out_valid) begin
        pulses++;
        if (sb.size() == 0) check("unexpected_pulse", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("data_out", 64'(data_out), 64'(e.d));
          check("latency", 64'(cyc - e.c), 64'd5);
        end
        check("done_with_pulse", 64'(done), 64'(pulses >= VC));
        last_out = data_out;
      end else begin
        check("data_out_hold", 64'(data_out), 64'(last_out));
      end
    end
  end

  task automatic issue(input logic [63:0] d, input logic [1:0] s, input logic [15:0] exp);
    logic rdy;
    bit ok;
    ok = 0;
    data_in = d; block_sel = s; data_in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      rdy = data_in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        sb.push_back(exp_t'{d: exp, c: cyc});
        ok = 1;
      end else @(negedge clk);
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_pulses(input int target);
    int k;
    k = 0;
    while (pulses < target && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    if (pulses < target) check("pulse_timeout", 64'(pulses), 64'(target));
  endtask

  task automatic run_vec(input logic [63:0] d, input logic [1:0] s, input logic [15:0] exp);
    alog.delete();
    issue(d, s, exp);
    @(negedge clk); data_in_valid = 1'b0;
    wait_pulses(pulses + 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 64'(data_in_ready), 64'd1);
    check("rst_w_en", 64'(w_en), 64'd0);
    check("rst_w_addr", 64'(w_addr), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_valid", 64'(data_out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
  endtask

  task automatic check_addrs(input logic [3:0] base);
    check("addr_count", 64'(alog.size()), 64'd4);
    for (int i = 0; i < 4 && i < alog.size(); i++)
      check("w_addr_seq", 64'(alog[i]), 64'(base + 4'(i)));
  endtask

  initial begin
    logic rdy;
    for (int i = 0; i < 16; i++) mem[i] = '1;
    mem[4][63:0]    = 64'h0;                     // neuron 0, block 1: 64 matches on zeros
    mem[5][127:64]  = 64'hFFFF_FFFE_0000_0000;   // neuron 5: 33 zeros
    mem[5][191:128] = 64'hFFFF_FFFF_0000_0000;   // neuron 6: 32 zeros (tie)
    mem[9][255:192] = 64'h0;                     // neuron 7, block 2

    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    run_vec(ONES, 2'd0, 16'hFFFF);
    check_addrs(4'd0);
    run_vec(64'h0, 2'd1, 16'h0021);
    run_vec(ONES, 2'd1, 16'hFF9E);
    run_vec(64'h0000_0000_FFFF_FFFF, 2'd3, 16'h0000);
    run_vec(64'h0000_0001_FFFF_FFFF, 2'd3, 16'hFFFF);

    // Select and valid changes during RUN must not disturb the vector in flight.
    alog.delete();
    issue(ONES, 2'd2, 16'hFF7F);
    @(negedge clk); block_sel = 2'd1; data_in = 64'h0;
    repeat (2) @(negedge clk);
    data_in_valid = 1'b0;
    wait_pulses(pulses + 1);
    repeat (3) @(negedge clk);
    check_addrs(4'd8);

    // Reset two cycles after acceptance.
    alog.delete();
    issue(ONES, 2'd0, 16'hFFFF);
    @(negedge clk); data_in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    sb.delete();
    #1 check_reset_outputs();
    pulses = 0; last_out = '0;
    @(negedge clk); rst = 1'b0;
    alog.delete();
    repeat (8) @(negedge clk);
    check("no_reads_after_reset", 64'(alog.size()), 64'd0);

    // Continuous valid: 30 vectors then terminal DONE.
    #1 data_in = ONES; block_sel = 2'd0; data_in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      rdy = data_in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        sb.push_back(exp_t'{d: 16'hFFFF, c: cyc});
        accepts++;
      end
      @(negedge clk);
    end
    data_in_valid = 1'b0;
    #1;
    check("accepts", 64'(accepts), 64'(VC));
    check("pulses", 64'(pulses), 64'(VC));
    check("done_sticky", 64'(done), 64'd1);
    check("ready_in_done", 64'(data_in_ready), 64'd0);
    check("w_en_in_done", 64'(done_wen), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
